// File: rtl/usb_line_pkg.sv
// Shared types for the USB receive line-state detector: line symbols, EOP error causes, FSM states.
package usb_line_pkg;

  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_K   = 2'b01,
    LS_J   = 2'b10,
    LS_SE1 = 2'b11
  } line_state_t;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_SHORT = 3'd1,
    ERR_LONG  = 3'd2,
    ERR_SE0_K = 3'd3,
    ERR_SE1   = 3'd4
  } err_code_t;

  typedef enum logic [1:0] {
    S_ACTIVE,
    S_SE0,
    S_ERR
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/usb_run_counter.sv
// Saturating run-length counter; zero has priority over inc.
module usb_run_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             inc,
  input  logic             zero,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (zero) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_C)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/usb_line_state_det.sv
// USB RX line-state detector: decodes {dp,dm}, validates EOP, flags malformed EOPs, reports idle.
// Optional bus-reset detection is built when USB_BUS_RESET_EN is defined.
//
// state    | meaning
// S_ACTIVE | normal traffic, no SE0 run in progress
// S_SE0    | inside an SE0 run that may still become a valid EOP
// S_ERR    | error flagged; waiting for J before flagging anything again
module usb_line_state_det
  import usb_line_pkg::*;
#(
  parameter int SE0_MIN    = 2,
  parameter int SE0_MAX    = 2,
  parameter int IDLE_BITS  = 7,
  parameter int RESET_BITS = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       en,
  input  logic       clear,
  input  logic       dp_in,
  input  logic       dm_in,
  output logic [1:0] line_state,
  output logic       eop,
  output logic       eop_error,
  output logic [2:0] err_code,
  output logic       idle,
  output logic       bus_reset
);

  localparam int CNT_W = $clog2(max3(SE0_MAX + 2, RESET_BITS + 1, IDLE_BITS + 1));
  localparam int SE0_SAT = (1 << CNT_W) - 1;

  localparam logic [CNT_W-1:0] SE0_MIN_C = CNT_W'(SE0_MIN);
  localparam logic [CNT_W-1:0] SE0_MAX_C = CNT_W'(SE0_MAX);
  localparam logic [CNT_W-1:0] IDLE_M1_C = CNT_W'(IDLE_BITS - 1);

  logic [1:0]       ls_in;
  logic             sample;
  logic             is_se0;
  logic             is_j;
  logic             is_se1;
  logic [CNT_W-1:0] se0_cnt;
  logic [CNT_W-1:0] j_cnt;
  state_t           state;

  assign ls_in  = {dp_in, dm_in};
  assign sample = en && !clear;
  assign is_se0 = (ls_in == LS_SE0);
  assign is_j   = (ls_in == LS_J);
  assign is_se1 = (ls_in == LS_SE1);

  usb_run_counter #(.WIDTH(CNT_W), .MAX(SE0_SAT)) u_se0_run (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (sample && is_se0),
    .zero  (clear || (sample && !is_se0)),
    .cnt   (se0_cnt)
  );

  usb_run_counter #(.WIDTH(CNT_W), .MAX(IDLE_BITS)) u_j_run (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (sample && is_j),
    .zero  (clear || (sample && !is_j)),
    .cnt   (j_cnt)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      line_state <= LS_J;
      state      <= S_ACTIVE;
      eop        <= 1'b0;
      eop_error  <= 1'b0;
      err_code   <= ERR_NONE;
      idle       <= 1'b0;
    end else begin
      eop       <= 1'b0;
      eop_error <= 1'b0;
      if (clear) begin
        state    <= S_ACTIVE;
        idle     <= 1'b0;
        err_code <= ERR_NONE;
      end else if (en) begin
        line_state <= ls_in;
        idle       <= is_j && (j_cnt >= IDLE_M1_C);
        // SE1 overrides everything, but S_ERR stays silent until a J re-arms it
        if (is_se1) begin
          if (state != S_ERR) begin
            eop_error <= 1'b1;
            err_code  <= ERR_SE1;
          end
          state <= S_ERR;
        end else begin
          case (state)
            S_ACTIVE: if (is_se0) state <= S_SE0;
            S_SE0: begin
              if (is_se0) begin
                if (se0_cnt == SE0_MAX_C) begin
                  eop_error <= 1'b1;
                  err_code  <= ERR_LONG;
                  state     <= S_ERR;
                end
              end else if (is_j) begin
                if ((se0_cnt >= SE0_MIN_C) && (se0_cnt <= SE0_MAX_C)) begin
                  eop <= 1'b1;
                end else begin
                  eop_error <= 1'b1;
                  err_code  <= ERR_SHORT;
                end
                state <= S_ACTIVE;
              end else begin
                eop_error <= 1'b1;
                err_code  <= ERR_SE0_K;
                state     <= S_ACTIVE;
              end
            end
            S_ERR: if (is_j) state <= S_ACTIVE;
            default: state <= S_ACTIVE;
          endcase
        end
      end
    end
  end

`ifdef USB_BUS_RESET_EN
  localparam logic [CNT_W-1:0] RESET_M1_C = CNT_W'(RESET_BITS - 1);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bus_reset <= 1'b0;
    end else if (clear) begin
      bus_reset <= 1'b0;
    end else if (en) begin
      bus_reset <= is_se0 && (se0_cnt >= RESET_M1_C);
    end
  end
`else
  assign bus_reset = 1'b0;
`endif

endmodule

// File: tb/tb_usb_line_state_det.sv
// Directed-vector bench for usb_line_state_det with default parameters.
module tb_usb_line_state_det;

  localparam logic [1:0] SE0 = 2'b00;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] SE1 = 2'b11;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       en;
  logic       clear;
  logic       dp_in;
  logic       dm_in;
  logic [1:0] line_state;
  logic       eop;
  logic       eop_error;
  logic [2:0] err_code;
  logic       idle;
  logic       bus_reset;

  int vectors = 0;
  int miscompares = 0;
  int err_pulses;

  usb_line_state_det dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .en         (en),
    .clear      (clear),
    .dp_in      (dp_in),
    .dm_in      (dm_in),
    .line_state (line_state),
    .eop        (eop),
    .eop_error  (eop_error),
    .err_code   (err_code),
    .idle       (idle),
    .bus_reset  (bus_reset)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [1:0] ls);
    {dp_in, dm_in} = ls;
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic pause();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pulses(input string tag, input logic e, input logic ee, input logic [2:0] code);
    chk({tag, ".eop"}, 8'(eop), 8'(e));
    chk({tag, ".eop_error"}, 8'(eop_error), 8'(ee));
    chk({tag, ".err_code"}, 8'(err_code), 8'(code));
  endtask

  initial begin
    n_rst = 1'b0;
    en    = 1'b0;
    clear = 1'b0;
    {dp_in, dm_in} = K;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.line_state", 8'(line_state), 8'h2);
    chk_pulses("rst", 1'b0, 1'b0, 3'd0);
    chk("rst.idle", 8'(idle), 8'h0);
    chk("rst.bus_reset", 8'(bus_reset), 8'h0);
    n_rst = 1'b1;
    pause();

    // valid EOP
    strobe(K);
    chk("k.line_state", 8'(line_state), 8'h1);
    strobe(K);
    strobe(SE0);
    chk("se0.line_state", 8'(line_state), 8'h0);
    chk_pulses("se0_1", 1'b0, 1'b0, 3'd0);
    strobe(SE0);
    chk_pulses("se0_2", 1'b0, 1'b0, 3'd0);
    strobe(J);
    chk_pulses("eop", 1'b1, 1'b0, 3'd0);
    pause();
    chk("eop_1clk", 8'(eop), 8'h0);
    chk("hold.line_state", 8'(line_state), 8'h2);

    // short EOP
    strobe(SE0);
    strobe(J);
    chk_pulses("short", 1'b0, 1'b1, 3'd1);
    pause();
    chk("short_1clk", 8'(eop_error), 8'h0);
    chk("short_hold.err_code", 8'(err_code), 8'h1);

    // long EOP, then silence until J
    strobe(SE0);
    strobe(SE0);
    chk_pulses("long_2", 1'b0, 1'b0, 3'd1);
    strobe(SE0);
    chk_pulses("long_3", 1'b0, 1'b1, 3'd2);
    strobe(SE0);
    chk_pulses("long_4", 1'b0, 1'b0, 3'd2);
    strobe(K);
    chk_pulses("long_k", 1'b0, 1'b0, 3'd2);
    strobe(J);
    chk_pulses("long_j", 1'b0, 1'b0, 3'd2);

    // SE1 inside SE0, then SE0 followed by K
    strobe(SE0);
    strobe(SE1);
    chk_pulses("se1", 1'b0, 1'b1, 3'd4);
    chk("se1.line_state", 8'(line_state), 8'h3);
    strobe(J);
    chk_pulses("se1_j", 1'b0, 1'b0, 3'd4);
    strobe(SE0);
    strobe(SE0);
    strobe(K);
    chk_pulses("se0k", 1'b0, 1'b1, 3'd3);
    strobe(K);
    chk_pulses("se0k_after", 1'b0, 1'b0, 3'd3);

    // idle after 7 J samples, dropped by K
    for (int i = 0; i < 6; i++) strobe(J);
    chk("idle_6", 8'(idle), 8'h0);
    strobe(J);
    chk("idle_7", 8'(idle), 8'h1);
    pause();
    chk("idle_hold", 8'(idle), 8'h1);
    strobe(K);
    chk("idle_k", 8'(idle), 8'h0);

    // clear mid-SE0 wins over the strobe and leaves line_state alone
    strobe(SE0);
    clear = 1'b1;
    strobe(J);
    clear = 1'b0;
    chk_pulses("clear", 1'b0, 1'b0, 3'd0);
    chk("clear.line_state", 8'(line_state), 8'h0);
    strobe(SE0);
    strobe(SE0);
    strobe(J);
    chk_pulses("after_clear_eop", 1'b1, 1'b0, 3'd0);

    // sixteen SE0 samples: one ERR_LONG, bus_reset only when built in
    strobe(K);
    err_pulses = 0;
    for (int i = 0; i < 15; i++) begin
      strobe(SE0);
      if (eop_error) err_pulses++;
    end
    chk("se0x15.bus_reset", 8'(bus_reset), 8'h0);
    strobe(SE0);
    if (eop_error) err_pulses++;
`ifdef USB_BUS_RESET_EN
    chk("se0x16.bus_reset", 8'(bus_reset), 8'h1);
`else
    chk("se0x16.bus_reset", 8'(bus_reset), 8'h0);
`endif
    strobe(SE0);
    if (eop_error) err_pulses++;
    strobe(J);
    if (eop_error) err_pulses++;
    chk("rst_seq.j.bus_reset", 8'(bus_reset), 8'h0);
    chk("rst_seq.err_pulses", 8'(err_pulses), 8'h1);
    chk_pulses("rst_seq.j", 1'b0, 1'b0, 3'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
